// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the instruction
// fetch port (if_*) and the load/store port (dm_*). Each access runs as a
// sequence: grant (IDLE) -> one-cycle strobe (ACCESS) -> fixed-latency wait
// (WAIT) -> registered response pulse (RESP).
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin arbitration with a one-bit last-granted pointer
//   undefined : fixed priority, dm beats if
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_gnt                   fetch grant (combinational, IDLE only)
//   if_rvalid/if_rdata       fetch response pulse and held read data
//   dm_req/dm_we/dm_wstrb    data request, write flag, byte enables
//   dm_addr/dm_wdata         data byte address and write data
//   dm_gnt                   data grant (combinational, IDLE only)
//   dm_rvalid/dm_rdata       data response pulse and held read data (0 for writes)
//   mem_en/mem_we/mem_wstrb  memory strobe, write enable, byte enables (registered)
//   mem_addr/mem_wdata       word-aligned address and write data (registered)
//   mem_rdata                memory read data
//   busy                     high whenever the sequencer is not in IDLE
module mem_arbiter #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [WORD_LEN-1:0] if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [3:0]          dm_wstrb,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [WORD_LEN-1:0] dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [WORD_LEN-1:0] dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [3:0]          mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  // Reject latencies the 4-bit counter cannot represent.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT=%0d is outside the legal range 1..15", MEM_LAT);
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_dm_q, win_dm_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [WORD_LEN-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_LEN-1:0] dm_rdata_q, dm_rdata_d;
  logic                busy_q, busy_d;
  logic                pick_dm_c;
  logic                idle_c;

  // Grants exist only in IDLE and are held off while reset is asserted.
  assign idle_c = (state_q == IDLE) & ~rst;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q, last_dm_d;

  // On a conflict the port that was not granted last wins.
  assign pick_dm_c = dm_req & (~if_req | ~last_dm_q);
  assign last_dm_d = dm_gnt ? 1'b1 : (if_gnt ? 1'b0 : last_dm_q);
`else
  assign pick_dm_c = dm_req;
`endif

  assign dm_gnt = idle_c & pick_dm_c;
  assign if_gnt = idle_c & if_req & ~pick_dm_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_dm_d    = win_dm_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wstrb_d = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        // The memory port registers are loaded straight from the winner's
        // fields so they are valid during the ACCESS cycle.
        if (dm_gnt) begin
          win_dm_d    = 1'b1;
          we_d        = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_wstrb_d = dm_we ? dm_wstrb : 4'b0000;
          mem_addr_d  = dm_addr & ~ADDR_W'(3);
          mem_wdata_d = dm_we ? dm_wdata : '0;
          state_d     = ACCESS;
        end else if (if_gnt) begin
          win_dm_d    = 1'b0;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr & ~ADDR_W'(3);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: capture the response and raise the pulse for RESP.
        if (cnt_q == CNT_W'(1)) begin
          if (win_dm_q) begin
            dm_rdata_d  = we_q ? '0 : mem_rdata;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_dm_q    <= win_dm_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= last_dm_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=4.
// Responses are predicted at grant time into per-instance queues and checked
// (port, data, arrival cycle) when the rvalid pulses appear.
`timescale 1ns/1ps
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        dm;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_if_req, a_if_gnt, a_if_rvalid, a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_dm_wstrb, a_mem_wstrb;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_dm_wstrb, b_mem_wstrb;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.WORD_LEN(32), .ADDR_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_wstrb(a_dm_wstrb), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_wstrb(a_mem_wstrb), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.WORD_LEN(32), .ADDR_W(32), .MEM_LAT(4)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_wstrb(b_dm_wstrb), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wstrb(b_mem_wstrb), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory model: read data is valid only in the cycle MEM_LAT-1 cycles after
  // the one following the strobe; garbage otherwise.
  logic [31:0] mem_arr [0:255];
  int          a_lat = 0;
  int          b_lat = 0;
  logic [31:0] a_rd_addr = '0;
  logic [31:0] b_rd_addr = '0;

  always @(posedge clk) begin
    if (a_mem_en) begin
      a_lat     <= 1;
      a_rd_addr <= a_mem_addr;
    end else if (a_lat > 0) begin
      a_lat <= a_lat - 1;
    end
    if (b_mem_en) begin
      b_lat     <= 4;
      b_rd_addr <= b_mem_addr;
    end else if (b_lat > 0) begin
      b_lat <= b_lat - 1;
    end
  end

  assign a_mem_rdata = (a_lat == 1) ? mem_arr[a_rd_addr[9:2]] : 32'hBAD0_BAD0;
  assign b_mem_rdata = (b_lat == 1) ? mem_arr[b_rd_addr[9:2]] : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Response monitors: every rvalid must match the head of its queue.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_if_rvalid === 1'b1 || a_dm_rvalid === 1'b1) begin
      chk("a_rvalid_expected", 64'(qa.size() != 0), 64'(1));
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_rvalid_port", 64'({a_dm_rvalid, a_if_rvalid}), e.dm ? 64'(2) : 64'(1));
        chk("a_rdata", 64'(e.dm ? a_dm_rdata : a_if_rdata), 64'(e.data));
        chk("a_rvalid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_if_rvalid === 1'b1 || b_dm_rvalid === 1'b1) begin
      chk("b_rvalid_expected", 64'(qb.size() != 0), 64'(1));
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_rvalid_port", 64'({b_dm_rvalid, b_if_rvalid}), e.dm ? 64'(2) : 64'(1));
        chk("b_rdata", 64'(e.dm ? b_dm_rdata : b_if_rdata), 64'(e.data));
        chk("b_rvalid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(qa.size() + qb.size()), 64'(0));
  endtask

  // Wait (bounded) for the next grant on instance a; it must land 4 cycles after c0.
  task automatic wait_gnt(input int c0, input string tag);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (a_if_gnt || a_dm_gnt) break;
    end
    chk(tag, 64'(cyc - c0), 64'(4));
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we,
                             a_mem_wstrb, a_busy}), 64'(0));
    chk({tag, "_mem_addr"}, 64'(a_mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(a_mem_wdata), 64'(0));
    chk({tag, "_rdata"}, {a_if_rdata, a_dm_rdata}, 64'(0));
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE_0000 | 32'(i);
    mem_arr[65] = 32'h00A0_0093;
    a_if_req = 0; a_if_addr = '0; a_dm_req = 0; a_dm_we = 0; a_dm_wstrb = '0;
    a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_wstrb = '0;
    b_dm_addr = '0; b_dm_wdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk_a_zero("reset");
    chk("reset_b_busy", 64'({b_busy, b_mem_en, b_if_rvalid}), 64'(0));

    // Single fetch, MEM_LAT=1.
    @(negedge clk);
    a_if_req = 1; a_if_addr = 32'h0000_0104;
    #1;
    chk("t1_if_gnt", 64'({a_if_gnt, a_dm_gnt}), 64'(2'b10));
    c0 = cyc;
    qa.push_back('{dm: 1'b0, data: 32'h00A0_0093, cyc: c0 + 3});
    @(posedge clk); #1 a_if_req = 0;
    @(negedge clk);
    chk("t1_mem_en_c1", 64'({a_mem_en, a_mem_we, a_mem_wstrb, a_busy}), 64'(7'b1000001));
    chk("t1_mem_addr_c1", 64'(a_mem_addr), 64'(32'h104));
    @(negedge clk);
    chk("t1_c2", 64'({a_mem_en, a_busy, a_if_rvalid}), 64'(3'b010));
    @(negedge clk);
    chk("t1_c3", 64'({a_if_rvalid, a_busy}), 64'(2'b11));
    @(negedge clk);
    chk("t1_c4", 64'({a_if_rvalid, a_busy}), 64'(0));
    chk("t1_rdata_hold", 64'(a_if_rdata), 64'(32'h00A0_0093));

    // Data write.
    a_dm_req = 1; a_dm_we = 1; a_dm_wstrb = 4'b0011; a_dm_addr = 32'h2002;
    a_dm_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_dm_gnt", 64'({a_if_gnt, a_dm_gnt}), 64'(2'b01));
    c0 = cyc;
    qa.push_back('{dm: 1'b1, data: 32'h0, cyc: c0 + 3});
    @(posedge clk); #1 a_dm_req = 0; a_dm_we = 0; a_dm_wstrb = '0;
    @(negedge clk);
    chk("t2_mem_ctl_c1", 64'({a_mem_en, a_mem_we, a_mem_wstrb}), 64'(6'b110011));
    chk("t2_mem_addr_c1", 64'(a_mem_addr), 64'(32'h2000));
    chk("t2_mem_wdata_c1", 64'(a_mem_wdata), 64'(32'hDEAD_BEEF));
    drain();

    // Data request raised during a fetch waits until cycle 4.
    @(negedge clk);
    a_if_req = 1; a_if_addr = 32'h10;
    #1;
    chk("t4_if_gnt", 64'(a_if_gnt), 64'(1));
    c0 = cyc;
    qa.push_back('{dm: 1'b0, data: 32'hC0DE_0004, cyc: c0 + 3});
    @(posedge clk); #1 a_if_req = 0;
    @(negedge clk);
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h20;
    #1;
    chk("t4_dm_gnt_c1", 64'(a_dm_gnt), 64'(0));
    wait_gnt(c0, "t4_dm_gnt_cycle");
    chk("t4_dm_gnt", 64'(a_dm_gnt), 64'(1));
    qa.push_back('{dm: 1'b1, data: 32'hC0DE_0008, cyc: cyc + 3});
    @(posedge clk); #1 a_dm_req = 0;
    drain();

    // Asynchronous reset during WAIT drops the transaction.
    @(negedge clk);
    a_if_req = 1; a_if_addr = 32'h104;
    #1;
    chk("t5_if_gnt", 64'(a_if_gnt), 64'(1));
    @(posedge clk); #1 a_if_req = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk_a_zero("t5_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    a_if_req = 1; a_if_addr = 32'h104;
    #1;
    chk("t5_regnt", 64'(a_if_gnt), 64'(1));
    qa.push_back('{dm: 1'b0, data: 32'h00A0_0093, cyc: cyc + 3});
    @(posedge clk); #1 a_if_req = 0;
    drain();

    // Simultaneous requests held for two transactions.
    @(negedge clk);
    a_if_req = 1; a_if_addr = 32'h10;
    a_dm_req = 1; a_dm_we = 0; a_dm_wstrb = '0; a_dm_addr = 32'h20;
    #1;
    chk("t3_first_gnt", 64'({a_if_gnt, a_dm_gnt}), 64'(2'b01));
    c0 = cyc;
    qa.push_back('{dm: 1'b1, data: 32'hC0DE_0008, cyc: c0 + 3});
    wait_gnt(c0, "t3_second_gnt_cycle");
    chk("t3_second_gnt", 64'({a_if_gnt, a_dm_gnt}), RR ? 64'(2'b10) : 64'(2'b01));
    qa.push_back('{dm: !RR, data: RR ? 32'hC0DE_0004 : 32'hC0DE_0008, cyc: cyc + 3});
    @(posedge clk); #1 a_if_req = 0; a_dm_req = 0;
    drain();

    // MEM_LAT=4 read on instance b.
    @(negedge clk);
    b_if_req = 1; b_if_addr = 32'h30;
    #1;
    chk("t6_if_gnt", 64'(b_if_gnt), 64'(1));
    c0 = cyc;
    qb.push_back('{dm: 1'b0, data: 32'hC0DE_000C, cyc: c0 + 6});
    @(posedge clk); #1 b_if_req = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t6_busy_c%0d", k), 64'(b_busy), 64'(k <= 6));
      chk($sformatf("t6_mem_en_c%0d", k), 64'(b_mem_en), 64'(k == 1));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
